// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_BUSY = 2'd1,
    ST_D_BUSY = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  // addi x0, x0, 0: returned to fetch when an access is aborted.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Access watchdog: counts busy cycles without a memory answer and flags expiry.
module arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry fires in the cycle whose increment would reach TIMEOUT_CYC.
  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (MEM); data side has priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_flush,
  output logic                  i_ready,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_ready,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e state_q;
  logic       discard_q;
  logic       in_busy;
  logic       wd_expire;

  assign in_busy = (state_q == ST_I_BUSY) || (state_q == ST_D_BUSY);
  assign busy    = (state_q != ST_IDLE);

  arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!in_busy),
    .en_i     (in_busy && !mem_ready),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      discard_q   <= 1'b0;
      i_ready     <= 1'b0;
      i_rdata     <= {DATA_W{1'b0}};
      d_ready     <= 1'b0;
      d_rdata     <= {DATA_W{1'b0}};
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= {ADDR_W{1'b0}};
      mem_wdata   <= {DATA_W{1'b0}};
      mem_be      <= {BE_W{1'b0}};
      timeout_err <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          discard_q <= 1'b0;
          if (d_req) begin
            state_q   <= ST_D_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
          end else if (i_req && !i_flush) begin
            state_q   <= ST_I_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= {DATA_W{1'b0}};
            mem_be    <= {BE_W{1'b1}};
          end else begin
            state_q <= ST_IDLE;
          end
        end
        // A flush landing on the completion cycle still discards the fetch.
        ST_I_BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state_q <= ST_RESP;
            if (!(discard_q || i_flush)) begin
              i_rdata <= mem_rdata;
              i_ready <= 1'b1;
            end else begin
              discard_q <= 1'b1;
            end
          end else if (wd_expire) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            state_q     <= ST_RESP;
            if (!(discard_q || i_flush)) begin
              i_rdata <= DATA_W'(NOP_INSTR);
              i_ready <= 1'b1;
            end else begin
              discard_q <= 1'b1;
            end
          end else begin
            discard_q <= discard_q || i_flush;
          end
        end
        ST_D_BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state_q <= ST_RESP;
            d_ready <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end else begin
              d_rdata <= d_rdata;
            end
          end else if (wd_expire) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            state_q     <= ST_RESP;
            d_ready     <= 1'b1;
            d_rdata     <= {DATA_W{1'b0}};
          end else begin
            state_q <= ST_D_BUSY;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected ready responses, checked at negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush, i_ready;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        busy, timeout_err;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   i_pulses = 0;
  int   d_pulses = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and retire any ready pulse against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (i_ready) begin
        i_pulses++;
        if (sb_q.size() == 0) chk("sb_underflow_i", 32'(sb_q.size()), 32'd1);
        else begin
          e = sb_q.pop_front();
          chk("sb_owner_i", {31'd0, e.is_d}, 32'd0);
          chk("i_rdata", i_rdata, e.data);
        end
      end
      if (d_ready) begin
        d_pulses++;
        if (sb_q.size() == 0) chk("sb_underflow_d", 32'(sb_q.size()), 32'd1);
        else begin
          e = sb_q.pop_front();
          chk("sb_owner_d", {31'd0, e.is_d}, 32'd1);
          chk("d_rdata", d_rdata, e.data);
        end
      end
    end
  endtask

  task automatic wait_mem_req();
    int n;
    n = 0;
    while (!mem_req && n < 50) begin
      tick();
      n++;
    end
    if (!mem_req) chk("mem_req_wait", {31'd0, mem_req}, 32'd1);
  endtask

  task automatic respond(input int lat, input logic [31:0] data);
    repeat (lat) tick();
    mem_ready = 1'b1;
    mem_rdata = data;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
    chk({tag, "_i_ready"}, {31'd0, i_ready}, 32'd0);
    chk({tag, "_d_ready"}, {31'd0, d_ready}, 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int ib, db, n;
    rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    tick();
    chk_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // 1: lone fetch, memory answers 2 cycles after mem_req
    ib = i_pulses;
    i_req = 1'b1; i_addr = 32'h10;
    sb_q.push_back('{is_d: 1'b0, data: 32'hC0DE_0001});
    wait_mem_req();
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t1_mem_be", {28'd0, mem_be}, 32'hF);
    respond(2, 32'hC0DE_0001);
    i_req = 1'b0;
    chk("t1_i_ready_latency", {31'd0, i_ready}, 32'd1);
    tick();
    chk("t1_i_ready_off", {31'd0, i_ready}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    repeat (2) tick();
    chk("t1_i_pulses", 32'(i_pulses - ib), 32'd1);

    // 2: simultaneous requests, store wins, fetch follows
    ib = i_pulses; db = d_pulses;
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    sb_q.push_back('{is_d: 1'b1, data: 32'h0});
    sb_q.push_back('{is_d: 1'b0, data: 32'hC0DE_0002});
    wait_mem_req();
    chk("t2_d_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t2_d_mem_be", {28'd0, mem_be}, 32'h3);
    chk("t2_d_mem_addr", mem_addr, 32'h100);
    chk("t2_d_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    respond(1, 32'h5555_5555);
    d_req = 1'b0; d_we = 1'b0;
    wait_mem_req();
    chk("t2_i_mem_addr", mem_addr, 32'h20);
    chk("t2_i_mem_we", {31'd0, mem_we}, 32'd0);
    respond(1, 32'hC0DE_0002);
    i_req = 1'b0;
    repeat (3) tick();
    chk("t2_i_pulses", 32'(i_pulses - ib), 32'd1);
    chk("t2_d_pulses", 32'(d_pulses - db), 32'd1);

    // 3: flush during I_BUSY discards the fetch, later load is normal
    ib = i_pulses; db = d_pulses;
    i_req = 1'b1; i_addr = 32'h30;
    wait_mem_req();
    i_flush = 1'b1; i_req = 1'b0;
    tick();
    i_flush = 1'b0;
    chk("t3_mem_req_held", {31'd0, mem_req}, 32'd1);
    respond(1, 32'h7777_7777);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    sb_q.push_back('{is_d: 1'b1, data: 32'h1234_5678});
    wait_mem_req();
    chk("t3_d_mem_addr", mem_addr, 32'h200);
    respond(1, 32'h1234_5678);
    d_req = 1'b0;
    repeat (3) tick();
    chk("t3_i_pulses", 32'(i_pulses - ib), 32'd0);
    chk("t3_d_pulses", 32'(d_pulses - db), 32'd1);
    chk("t3_i_rdata_kept", i_rdata, 32'hC0DE_0002);

    // 4: memory never answers, watchdog aborts after 4 busy cycles
    ib = i_pulses;
    i_req = 1'b1; i_addr = 32'h40;
    sb_q.push_back('{is_d: 1'b0, data: 32'h0000_0013});
    wait_mem_req();
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      tick();
    end
    i_req = 1'b0;
    chk("t4_busy_cycles", 32'(n), 32'd4);
    chk("t4_timeout_err", {31'd0, timeout_err}, 32'd1);
    repeat (4) tick();
    chk("t4_timeout_sticky", {31'd0, timeout_err}, 32'd1);
    chk("t4_i_pulses", 32'(i_pulses - ib), 32'd1);

    // 5: mem_ready on the expiry cycle completes normally
    do_reset();
    ib = i_pulses;
    i_req = 1'b1; i_addr = 32'h50;
    sb_q.push_back('{is_d: 1'b0, data: 32'hCAFE_0005});
    wait_mem_req();
    respond(3, 32'hCAFE_0005);
    i_req = 1'b0;
    repeat (3) tick();
    chk("t5_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("t5_i_pulses", 32'(i_pulses - ib), 32'd1);

    // 6: reset in the middle of a load, then a stray mem_ready
    db = d_pulses;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    sb_q.push_back('{is_d: 1'b1, data: 32'h6666_0006});
    wait_mem_req();
    respond(1, 32'h6666_0006);
    d_req = 1'b0;
    repeat (2) tick();
    d_req = 1'b1; d_addr = 32'h304;
    wait_mem_req();
    tick();
    rst = 1'b1; d_req = 1'b0;
    tick();
    chk_all_zero("t6_rst");
    rst = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (3) tick();
    chk_all_zero("t6_after");
    chk("t6_d_pulses", 32'(d_pulses - db), 32'd1);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
